// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: funct3 codes, writeback select
// encodings and the memory-access FSM state type.
package mem_wb_stage_pkg;

    // Load funct3 codes
    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    // Writeback data source select
    localparam logic [2:0] SelAlu    = 3'b000;
    localparam logic [2:0] SelLoad   = 3'b001;
    localparam logic [2:0] SelPc4    = 3'b010;
    localparam logic [2:0] SelImm    = 3'b011;
    localparam logic [2:0] SelBranch = 3'b100;

    typedef enum logic {
        StIdle,
        StAccess
    } memState_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the addressed lane out of the read
// word and sign- or zero-extends it according to the load type.
module load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  byteOffset,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed byte and halfword lanes
    always_comb begin
        byteSel = rdata[7:0];
        case (byteOffset)
            2'd0:    byteSel = rdata[7:0];
            2'd1:    byteSel = rdata[15:8];
            2'd2:    byteSel = rdata[23:16];
            default: byteSel = rdata[31:24];
        endcase
        halfSel = byteOffset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane to a full word
    always_comb begin
        loadData = '0;
        case (funct)
            Funct3Lb:  loadData = {{24{byteSel[7]}}, byteSel};
            Funct3Lh:  loadData = {{16{halfSel[15]}}, halfSel};
            Funct3Lw:  loadData = rdata;
            Funct3Lbu: loadData = {24'd0, byteSel};
            Funct3Lhu: loadData = {16'd0, halfSel};
            default:   loadData = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives the data-memory handshake for loads and
// stores, stalls earlier stages while an access is outstanding, flags
// misaligned accesses and holds the registered writeback outputs.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] MEM_PCplus4,
    input  logic [31:0] MEM_BranchAddr,
    input  logic [31:0] MEM_immediate,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_WriteMemData,
    input  logic [4:0]  MEM_WriteRegNum,
    input  logic [2:0]  MEM_funct,
    input  logic [2:0]  MEM_sel_MemToReg,
    input  logic        MEM_cntl_MemWrite,
    input  logic        MEM_cntl_MemRead,
    input  logic        MEM_cntl_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] WB_WriteData,
    output logic [4:0]  WB_WriteRegNum,
    output logic        WB_cntl_RegWrite,
    output logic        WB_misaligned
);

    memState_e   stateQ, stateD;
    logic        access, isStore, aligned;
    logic        startAccess, misalign;
    logic [31:0] loadData, selData;
    logic [31:0] wbDataQ, wbDataD;
    logic [4:0]  wbRegQ, wbRegD;
    logic        wbWriteQ, wbWriteD;
    logic        wbMisQ, wbMisD;

    // A request with both read and write set is treated as a load
    assign access  = MEM_cntl_MemRead | MEM_cntl_MemWrite;
    assign isStore = MEM_cntl_MemWrite & ~MEM_cntl_MemRead;

    // Alignment check from the access size in funct[1:0]
    always_comb begin
        aligned = 1'b1;
        case (MEM_funct[1:0])
            2'b10:   aligned = (MEM_ALUResult[1:0] == 2'b00);
            2'b01:   aligned = ~MEM_ALUResult[0];
            default: aligned = 1'b1;
        endcase
    end

    assign startAccess = (stateQ == StIdle) & access & aligned;
    assign misalign    = (stateQ == StIdle) & access & ~aligned;
    assign mem_stall   = startAccess | ((stateQ == StAccess) & ~dmem_ack);

    // Access FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state and memory request outputs; inputs are held by the stall
    always_comb begin
        stateD     = stateQ;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = {MEM_ALUResult[31:2], 2'b00};
        dmem_be    = 4'b1111;
        dmem_wdata = MEM_WriteMemData;
        case (stateQ)
            StIdle: begin
                if (startAccess) begin
                    stateD = StAccess;
                end
            end
            StAccess: begin
                dmem_req = 1'b1;
                dmem_we  = isStore;
                if (dmem_ack) begin
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
        if (isStore) begin
            case (MEM_funct[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << MEM_ALUResult[1:0];
                    dmem_wdata = {4{MEM_WriteMemData[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << MEM_ALUResult[1:0];
                    dmem_wdata = {2{MEM_WriteMemData[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = MEM_WriteMemData;
                end
            endcase
        end
    end

    load_align uLoadAlign (
        .funct      (MEM_funct),
        .byteOffset (MEM_ALUResult[1:0]),
        .rdata      (dmem_rdata),
        .loadData   (loadData)
    );

    // Writeback data source mux
    always_comb begin
        selData = '0;
        case (MEM_sel_MemToReg)
            SelAlu:    selData = MEM_ALUResult;
            SelLoad:   selData = loadData;
            SelPc4:    selData = MEM_PCplus4;
            SelImm:    selData = MEM_immediate;
            SelBranch: selData = MEM_BranchAddr;
            default:   selData = '0;
        endcase
    end

    // Next WB contents: bubble while stalled, exception flag on misalignment
    always_comb begin
        wbDataD  = selData;
        wbRegD   = MEM_WriteRegNum;
        wbWriteD = MEM_cntl_RegWrite & (MEM_WriteRegNum != 5'd0);
        wbMisD   = 1'b0;
        if (mem_stall) begin
            wbDataD  = '0;
            wbRegD   = '0;
            wbWriteD = 1'b0;
        end else if (misalign) begin
            wbDataD  = '0;
            wbRegD   = '0;
            wbWriteD = 1'b0;
            wbMisD   = 1'b1;
        end
    end

    // WB pipeline register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbDataQ  <= '0;
            wbRegQ   <= '0;
            wbWriteQ <= 1'b0;
            wbMisQ   <= 1'b0;
        end else begin
            wbDataQ  <= wbDataD;
            wbRegQ   <= wbRegD;
            wbWriteQ <= wbWriteD;
            wbMisQ   <= wbMisD;
        end
    end

    assign WB_WriteData     = wbDataQ;
    assign WB_WriteRegNum   = wbRegQ;
    assign WB_cntl_RegWrite = wbWriteQ;
    assign WB_misaligned    = wbMisQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: per-instruction transaction model
// producing a per-cycle expectation queue, plus directed literal checks.
module tb_mem_wb_stage;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
    } wb_t;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        wb_t         wb;
    } cyc_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] br;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] wmd;
        logic [4:0]  rd;
        logic [2:0]  funct;
        logic [2:0]  sel;
        logic        mw;
        logic        mr;
        logic        rw;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] MEM_PCplus4, MEM_BranchAddr, MEM_immediate, MEM_ALUResult, MEM_WriteMemData;
    logic [4:0]  MEM_WriteRegNum;
    logic [2:0]  MEM_funct, MEM_sel_MemToReg;
    logic        MEM_cntl_MemWrite, MEM_cntl_MemRead, MEM_cntl_RegWrite;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall;
    logic [31:0] WB_WriteData;
    logic [4:0]  WB_WriteRegNum;
    logic        WB_cntl_RegWrite, WB_misaligned;

    int          checks = 0;
    int          failures = 0;
    int          stallCnt = 0;
    int          reqCnt = 0;
    logic        capWe = 1'b0;
    logic [3:0]  capBe = '0;
    logic [31:0] capWd = '0;
    cyc_t        expQ[$];
    cyc_t        cmpE;
    wb_t         lastWb = '0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .MEM_PCplus4       (MEM_PCplus4),
        .MEM_BranchAddr    (MEM_BranchAddr),
        .MEM_immediate     (MEM_immediate),
        .MEM_ALUResult     (MEM_ALUResult),
        .MEM_WriteMemData  (MEM_WriteMemData),
        .MEM_WriteRegNum   (MEM_WriteRegNum),
        .MEM_funct         (MEM_funct),
        .MEM_sel_MemToReg  (MEM_sel_MemToReg),
        .MEM_cntl_MemWrite (MEM_cntl_MemWrite),
        .MEM_cntl_MemRead  (MEM_cntl_MemRead),
        .MEM_cntl_RegWrite (MEM_cntl_RegWrite),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_be           (dmem_be),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .WB_WriteData      (WB_WriteData),
        .WB_WriteRegNum    (WB_WriteRegNum),
        .WB_cntl_RegWrite  (WB_cntl_RegWrite),
        .WB_misaligned     (WB_misaligned)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic isAligned(input logic [2:0] f, input logic [1:0] a);
        if (f[1:0] == 2'b10) return a == 2'b00;
        if (f[1:0] == 2'b01) return a[0] == 1'b0;
        return 1'b1;
    endfunction

    function automatic logic isStoreOp(input instr_t i);
        return i.mw && !i.mr;
    endfunction

    function automatic logic [3:0] expBe(input instr_t i);
        if (!isStoreOp(i)) return 4'b1111;
        if (i.funct[1:0] == 2'b00) begin
            case (i.alu[1:0])
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (i.funct[1:0] == 2'b01) begin
            case (i.alu[1:0])
                2'd0:    return 4'b0011;
                2'd1:    return 4'b0110;
                2'd2:    return 4'b1100;
                default: return 4'b1000;
            endcase
        end
        return 4'b1111;
    endfunction

    function automatic logic [31:0] expWd(input instr_t i);
        if (isStoreOp(i) && i.funct[1:0] == 2'b00) return {4{i.wmd[7:0]}};
        if (isStoreOp(i) && i.funct[1:0] == 2'b01) return {2{i.wmd[15:0]}};
        return i.wmd;
    endfunction

    function automatic logic [31:0] loadVal(input logic [2:0] f, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] shifted;
        logic [7:0]  b8;
        logic [15:0] h16;
        shifted = w >> {off, 3'b000};
        b8      = shifted[7:0];
        h16     = off[1] ? w[31:16] : w[15:0];
        case (f)
            3'b000:  return {{24{b8[7]}}, b8};
            3'b001:  return {{16{h16[15]}}, h16};
            3'b010:  return w;
            3'b100:  return {24'd0, b8};
            3'b101:  return {16'd0, h16};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] selVal(input instr_t i, input logic [31:0] ld);
        case (i.sel)
            3'd0:    return i.alu;
            3'd1:    return ld;
            3'd2:    return i.pc4;
            3'd3:    return i.imm;
            3'd4:    return i.br;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input instr_t i);
        MEM_PCplus4       = i.pc4;
        MEM_BranchAddr    = i.br;
        MEM_immediate     = i.imm;
        MEM_ALUResult     = i.alu;
        MEM_WriteMemData  = i.wmd;
        MEM_WriteRegNum   = i.rd;
        MEM_funct         = i.funct;
        MEM_sel_MemToReg  = i.sel;
        MEM_cntl_MemWrite = i.mw;
        MEM_cntl_MemRead  = i.mr;
        MEM_cntl_RegWrite = i.rw;
    endtask

    // Present one instruction until it retires; lat = ACCESS cycles before ack
    task automatic runInstr(input instr_t ins, input int lat, input logic [31:0] ackData);
        cyc_t        e;
        wb_t         fin;
        logic        memOp, al;
        int          n;
        logic [31:0] rdv;
        memOp = ins.mr | ins.mw;
        al    = isAligned(ins.funct, ins.alu[1:0]);
        n     = (memOp && al) ? lat + 1 : 0;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk);
            #1;
            drive(ins);
            rdv        = (c == n) ? ackData : $urandom;
            dmem_rdata = rdv;
            if (n > 0 && c == n) dmem_ack = 1'b1;
            else if (c == 0)     dmem_ack = 1'($urandom_range(0, 1));
            else                 dmem_ack = 1'b0;
            e.stall = (c < n);
            e.req   = (n > 0) && (c > 0);
            e.we    = e.req && isStoreOp(ins);
            e.addr  = {ins.alu[31:2], 2'b00};
            e.be    = expBe(ins);
            e.wdata = expWd(ins);
            if (memOp && !al) begin
                fin.data = 32'd0;
                fin.rd   = 5'd0;
                fin.rw   = 1'b0;
                fin.mis  = 1'b1;
            end else begin
                fin.data = selVal(ins, loadVal(ins.funct, ins.alu[1:0], rdv));
                fin.rd   = ins.rd;
                fin.rw   = ins.rw && (ins.rd != 5'd0);
                fin.mis  = 1'b0;
            end
            e.wb = (c < n) ? wb_t'('0) : fin;
            expQ.push_back(e);
        end
    endtask

    // Per-cycle compare against the model queue
    always @(negedge clk) begin
        if (mem_stall) stallCnt++;
        if (dmem_req) begin
            reqCnt++;
            capWe = dmem_we;
            capBe = dmem_be;
            capWd = dmem_wdata;
        end
        if (expQ.size() > 0) begin
            cmpE = expQ.pop_front();
            chk("wb_data", WB_WriteData, lastWb.data);
            chk("wb_rd", 32'(WB_WriteRegNum), 32'(lastWb.rd));
            chk("wb_regwrite", 32'(WB_cntl_RegWrite), 32'(lastWb.rw));
            chk("wb_misaligned", 32'(WB_misaligned), 32'(lastWb.mis));
            chk("mem_stall", 32'(mem_stall), 32'(cmpE.stall));
            chk("dmem_req", 32'(dmem_req), 32'(cmpE.req));
            if (cmpE.req) begin
                chk("dmem_we", 32'(dmem_we), 32'(cmpE.we));
                chk("dmem_addr", dmem_addr, cmpE.addr);
                chk("dmem_be", 32'(dmem_be), 32'(cmpE.be));
                chk("dmem_wdata", dmem_wdata, cmpE.wdata);
            end else begin
                chk("dmem_we_idle", 32'(dmem_we), 32'd0);
            end
            lastWb = cmpE.wb;
        end
    end

    instr_t     nop, ins;
    logic [2:0] loadF[5];
    int         snapA, snapB, kind;

    initial begin
        nop      = '0;
        loadF    = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset_n  = 1'b0;
        drive(nop);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_data", WB_WriteData, 32'd0);
        chk("rst_wb_regwrite", 32'(WB_cntl_RegWrite), 32'd0);
        chk("rst_wb_mis", 32'(WB_misaligned), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ALU result writeback, no stall
        ins = nop; ins.alu = 32'h5; ins.rd = 5'd3; ins.rw = 1'b1;
        snapA = stallCnt;
        runInstr(ins, 0, 32'd0);
        runInstr(nop, 0, 32'd0);
        chk("alu_data", WB_WriteData, 32'h5);
        chk("alu_regwrite", 32'(WB_cntl_RegWrite), 32'd1);
        chk("alu_rd", 32'(WB_WriteRegNum), 32'd3);
        chk("alu_nostall", 32'(stallCnt - snapA), 32'd0);

        // LB from 0x103 with two wait cycles
        ins = nop; ins.alu = 32'h103; ins.mr = 1'b1; ins.funct = 3'b000;
        ins.sel = 3'b001; ins.rd = 5'd5; ins.rw = 1'b1;
        snapA = stallCnt;
        runInstr(ins, 2, 32'h80FF_0000);
        runInstr(nop, 0, 32'd0);
        chk("lb_data", WB_WriteData, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(stallCnt - snapA), 32'd3);
        chk("lb_be", 32'(capBe), 32'hF);

        // SH to 0x102
        ins = nop; ins.alu = 32'h102; ins.mw = 1'b1; ins.funct = 3'b001;
        ins.wmd = 32'h0000_BEEF; ins.rd = 5'd0;
        runInstr(ins, 1, 32'd0);
        runInstr(nop, 0, 32'd0);
        chk("sh_we", 32'(capWe), 32'd1);
        chk("sh_be", 32'(capBe), 32'hC);
        chk("sh_wdata", capWd, 32'hBEEF_BEEF);
        chk("sh_regwrite", 32'(WB_cntl_RegWrite), 32'd0);

        // Misaligned LW at 0x101
        ins = nop; ins.alu = 32'h101; ins.mr = 1'b1; ins.funct = 3'b010;
        ins.sel = 3'b001; ins.rd = 5'd7; ins.rw = 1'b1;
        snapB = reqCnt;
        runInstr(ins, 0, 32'd0);
        runInstr(nop, 0, 32'd0);
        chk("lw_mis_flag", 32'(WB_misaligned), 32'd1);
        chk("lw_mis_regwrite", 32'(WB_cntl_RegWrite), 32'd0);
        chk("lw_mis_noreq", 32'(reqCnt - snapB), 32'd0);
        runInstr(nop, 0, 32'd0);
        chk("lw_mis_oneshot", 32'(WB_misaligned), 32'd0);

        // PC+4 to x0 must not write
        ins = nop; ins.sel = 3'b010; ins.pc4 = 32'h1004; ins.rd = 5'd0; ins.rw = 1'b1;
        runInstr(ins, 0, 32'd0);
        runInstr(nop, 0, 32'd0);
        chk("pc4_data", WB_WriteData, 32'h1004);
        chk("pc4_x0_regwrite", 32'(WB_cntl_RegWrite), 32'd0);

        // Randomized instruction stream
        for (int k = 0; k < 250; k++) begin
            ins.pc4 = $urandom; ins.br = $urandom; ins.imm = $urandom;
            ins.alu = $urandom; ins.wmd = $urandom;
            ins.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            ins.sel = 3'($urandom);
            ins.rw  = 1'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                ins.mr = 1'b0; ins.mw = 1'b0; ins.funct = 3'($urandom);
            end else if (kind < 7) begin
                ins.mr = 1'b1; ins.mw = (kind == 6) ? 1'($urandom) : 1'b0;
                ins.funct = loadF[$urandom_range(0, 4)];
            end else begin
                ins.mr = 1'b0; ins.mw = 1'b1; ins.funct = 3'($urandom_range(0, 2));
            end
            runInstr(ins, $urandom_range(0, 3), $urandom);
        end

        // Reset during ACCESS, then a stray ack after release
        runInstr(nop, 0, 32'd0);
        @(posedge clk);
        #1;
        ins = nop; ins.alu = 32'h200; ins.mr = 1'b1; ins.funct = 3'b010;
        ins.sel = 3'b001; ins.rd = 5'd9; ins.rw = 1'b1;
        drive(ins);
        dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("access_req", 32'(dmem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(dmem_req), 32'd0);
        chk("rstmid_we", 32'(dmem_we), 32'd0);
        chk("rstmid_wb_data", WB_WriteData, 32'd0);
        chk("rstmid_wb_regwrite", 32'(WB_cntl_RegWrite), 32'd0);
        drive(nop);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_wb_data", WB_WriteData, 32'd0);
        chk("late_ack_wb_regwrite", 32'(WB_cntl_RegWrite), 32'd0);
        @(posedge clk);
        #1;
        chk("late_ack_idle_req", 32'(dmem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
